// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block: FSM state encodings and the
// default button debounce count.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    ST_GET_A = 2'd0,
    ST_GET_B = 2'd1,
    ST_ARMED = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, accepted level and
// a one-cycle pulse on an accepted press (release gives no pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = operand_entry_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level has disagreed for DEBOUNCE_CYCLES consecutive cycles: accept it.
        cnt   <= '0;
        level <= sync_2;
        press <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: debounced load/go buttons capture switch operands
// and launch the FP adder. Optional OPERAND_ENTRY_AUTO_START_EN launches on the B capture.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_go,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             start,
  output logic             show_sum,
  output logic [1:0]       state_led
);

  logic [WIDTH-1:0] sw_sync_1;
  logic [WIDTH-1:0] sw_sync_2;
  logic             load_p;
  logic             go_p;
  state_t           state;
  state_t           state_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (clk),
    .clr   (clr),
    .raw   (btn_load),
    .press (load_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (
    .clk   (clk),
    .clr   (clr),
    .raw   (btn_go),
    .press (go_p)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sw_sync_1 <= '0;
      sw_sync_2 <= '0;
    end else begin
      sw_sync_1 <= sw;
      sw_sync_2 <= sw_sync_1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_GET_A;
    else      state <= state_next;
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; any path that leaves state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_GET_A: if (load_p) state_next = ST_GET_B;
`ifdef OPERAND_ENTRY_AUTO_START_EN
      ST_GET_B: if (load_p) state_next = ST_SHOW;
`else
      ST_GET_B: if (load_p) state_next = ST_ARMED;
`endif
      // Load wins a same-cycle tie, and ARMED has no load transition.
      ST_ARMED: if (go_p && !load_p) state_next = ST_SHOW;
      ST_SHOW:  if (load_p) state_next = ST_GET_B;
      default:  state_next = ST_GET_A;
    endcase
  end

  // Operand, start and display registers, all decided from the current state
  // and this cycle's press pulses.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a        <= '0;
      b        <= '0;
      start    <= 1'b0;
      show_sum <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_GET_A: if (load_p) a <= sw_sync_2;
        ST_GET_B: begin
          if (load_p) begin
            b <= sw_sync_2;
`ifdef OPERAND_ENTRY_AUTO_START_EN
            start    <= 1'b1;
            show_sum <= 1'b1;
`endif
          end
        end
        ST_ARMED: begin
          if (go_p && !load_p) begin
            start    <= 1'b1;
            show_sum <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (load_p) begin
            show_sum <= 1'b0;
            a        <= sw_sync_2;
          end
`ifdef OPERAND_ENTRY_AUTO_START_EN
          else if (go_p) begin
            start <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_led = state;
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEBOUNCE_CYCLES=4; the
// OPERAND_ENTRY_AUTO_START_EN build runs the auto-launch sequence instead.
module tb_operand_entry;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic             btn_load = 1'b0;
  logic             btn_go = 1'b0;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic             show_sum;
  logic [1:0]       state_led;

  int n_compared   = 0;
  int n_mismatched = 0;
  int start_count  = 0;
  int start_double = 0;
  logic prev_start = 1'b0;

  operand_entry #(.DEBOUNCE_CYCLES(4), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_go    (btn_go),
    .a         (a),
    .b         (b),
    .start     (start),
    .show_sum  (show_sum),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  // Start pulses and back-to-back starts, sampled mid-cycle.
  always @(negedge clk) begin
    if (start) begin
      start_count++;
      if (prev_start) start_double++;
    end
    prev_start = start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the chosen buttons for 'hold' cycles, then release and let things settle.
  task automatic press(input bit ld, input bit go, input int hold);
    @(negedge clk);
    btn_load = ld;
    btn_go   = go;
    repeat (hold) @(negedge clk);
    btn_load = 1'b0;
    btn_go   = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                               input logic es, input logic [1:0] el);
    check({tag, "_a"}, 32'(a), 32'(ea));
    check({tag, "_b"}, 32'(b), 32'(eb));
    check({tag, "_show"}, 32'(show_sum), 32'(es));
    check({tag, "_led"}, 32'(state_led), 32'(el));
  endtask

  initial begin
    int sc;
    // Reset held while buttons toggle.
    clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      btn_load = i[1];
      btn_go   = i[2];
      sw       = 8'(i * 17);
      @(negedge clk);
    end
    btn_load = 1'b0;
    btn_go   = 1'b0;
    check_outputs("rst_hold", 8'h00, 8'h00, 1'b0, 2'd0);
    check("rst_hold_start", 32'(start_count), 32'd0);
    clr = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs("rst_rel", 8'h00, 8'h00, 1'b0, 2'd0);

`ifdef OPERAND_ENTRY_AUTO_START_EN
    sw = 8'h3C; press(1'b1, 1'b0, 10);
    check_outputs("auto_a", 8'h3C, 8'h00, 1'b0, 2'd1);
    sw = 8'h41; press(1'b1, 1'b0, 10);
    check_outputs("auto_b", 8'h3C, 8'h41, 1'b1, 2'd3);
    check("auto_start1", 32'(start_count), 32'd1);
    sw = 8'h99; press(1'b0, 1'b1, 10);
    check_outputs("auto_relaunch", 8'h3C, 8'h41, 1'b1, 2'd3);
    check("auto_start2", 32'(start_count), 32'd2);
`else
    // Go in GET_A is ignored.
    press(1'b0, 1'b1, 10);
    check_outputs("go_in_get_a", 8'h00, 8'h00, 1'b0, 2'd0);
    check("go_in_get_a_start", 32'(start_count), 32'd0);

    sw = 8'h3C; press(1'b1, 1'b0, 10);
    check_outputs("load_a", 8'h3C, 8'h00, 1'b0, 2'd1);
    sw = 8'h41; press(1'b1, 1'b0, 10);
    check_outputs("load_b", 8'h3C, 8'h41, 1'b0, 2'd2);
    check("armed_no_start", 32'(start_count), 32'd0);
    press(1'b0, 1'b1, 10);
    check_outputs("go", 8'h3C, 8'h41, 1'b1, 2'd3);
    check("go_start_once", 32'(start_count), 32'd1);

    // Go in SHOW is ignored in this build.
    press(1'b0, 1'b1, 10);
    check("go_in_show", 32'(start_count), 32'd1);

    // Two-cycle glitch is rejected.
    sw = 8'h55; press(1'b1, 1'b0, 2);
    check_outputs("glitch", 8'h3C, 8'h41, 1'b1, 2'd3);

    // Long hold captures exactly once: SHOW -> GET_B, b untouched.
    press(1'b1, 1'b0, 10);
    check_outputs("long_hold", 8'h55, 8'h41, 1'b0, 2'd1);

    // Go in GET_B is ignored.
    press(1'b0, 1'b1, 10);
    check("go_in_get_b_led", 32'(state_led), 32'd1);

    sw = 8'h66; press(1'b1, 1'b0, 10);
    check_outputs("armed_again", 8'h55, 8'h66, 1'b0, 2'd2);

    // Same-cycle load and go in ARMED: no start, stay in ARMED.
    sw = 8'h77; press(1'b1, 1'b1, 10);
    check_outputs("simul", 8'h55, 8'h66, 1'b0, 2'd2);
    check("simul_start", 32'(start_count), 32'd1);

    // Abort: reset lands in the cycle after the go press pulse.
    // btn_go rises before P1; press pulse follows P6; start would follow P7.
    sc = start_count;
    @(negedge clk);
    btn_go = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    btn_go = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("abort_hold", 8'h00, 8'h00, 1'b0, 2'd0);
    clr = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs("abort_rel", 8'h00, 8'h00, 1'b0, 2'd0);
    check("abort_no_start", 32'(start_count), 32'(sc));
`endif

    check("no_double_start", 32'(start_double), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
